// File: rtl/i2c_target.sv
// I2C target: 16 x 8-bit register file behind address ADDRESS; every addressed byte is ACKed, writes are also strobed to fabric.
// Latency: pad -> decision 2 sync + FILTER samples; no clock stretching, host port never stalled, host_rd_data 1 cycle.
module i2c_target #(
    parameter logic [6:0] ADDRESS = 7'h42,
    parameter int         FILTER  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       i2c_wr_stb,
    output logic [3:0] i2c_wr_addr,
    output logic [7:0] i2c_wr_data,
    input  logic       host_wr_stb,
    input  logic [3:0] host_wr_addr,
    input  logic [7:0] host_wr_data,
    input  logic [3:0] host_rd_addr,
    output logic [7:0] host_rd_data,
    output logic       busy
);

    localparam int            CW       = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] FLT_LAST = CW'(FILTER - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_MACK
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_nxt;
    logic [3:0] bit_cnt, cnt_nxt;
    logic [7:0] sh, sh_nxt, tx, tx_nxt, rx_byte, rd_byte;
    logic [3:0] ptr, ptr_nxt;
    logic       rw, rw_nxt, oe_nxt, busy_nxt, i2c_we;
    logic [7:0] regs [16];

    // Filtered levels reset high so an idle bus after reset is not mistaken for a condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_cnt  <= '0;
            sda_cnt  <= '0;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_q    <= scl_f;
            sda_q    <= sda_f;
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLT_LAST) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLT_LAST) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {sh[6:0], sda_f};
    assign rd_byte   = regs[ptr];

    // In ACK states sda_oe doubles as the phase: first fall drives ACK, second fall ends the slot.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        sh_nxt    = sh;
        tx_nxt    = tx;
        ptr_nxt   = ptr;
        rw_nxt    = rw;
        oe_nxt    = sda_oe;
        busy_nxt  = busy;
        i2c_we    = 1'b0;
        if (start_det) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = 4'd0;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    sh_nxt  = rx_byte;
                    cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        cnt_nxt = 4'd0;
                        if (rx_byte[7:1] == ADDRESS) begin
                            state_nxt = ST_ADDR_ACK;
                            rw_nxt    = rx_byte[0];
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_nxt = 1'b1;
                    end else if (rw) begin
                        tx_nxt    = rd_byte;
                        oe_nxt    = ~rd_byte[7];
                        cnt_nxt   = 4'd1;
                        state_nxt = ST_RDATA;
                    end else begin
                        oe_nxt    = 1'b0;
                        state_nxt = ST_PTR;
                    end
                end
                ST_PTR: if (scl_rise) begin
                    sh_nxt  = rx_byte;
                    cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        ptr_nxt   = rx_byte[3:0];
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_nxt = 1'b1;
                    end else begin
                        oe_nxt    = 1'b0;
                        state_nxt = ST_WDATA;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    sh_nxt  = rx_byte;
                    cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        i2c_we    = 1'b1;
                        ptr_nxt   = ptr + 4'd1;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_WDATA_ACK;
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        oe_nxt    = 1'b0;
                        ptr_nxt   = ptr + 4'd1;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_MACK;
                    end else begin
                        oe_nxt  = ~tx[~bit_cnt[2:0]];
                        cnt_nxt = bit_cnt + 4'd1;
                    end
                end
                ST_MACK: if (scl_rise) begin
                    if (sda_f) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        tx_nxt    = rd_byte;
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_RDATA;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            sh          <= '0;
            tx          <= '0;
            ptr         <= '0;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            i2c_wr_stb  <= 1'b0;
            i2c_wr_addr <= '0;
            i2c_wr_data <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= cnt_nxt;
            sh         <= sh_nxt;
            tx         <= tx_nxt;
            ptr        <= ptr_nxt;
            rw         <= rw_nxt;
            sda_oe     <= oe_nxt;
            busy       <= busy_nxt;
            i2c_wr_stb <= i2c_we;
            if (i2c_we) begin
                i2c_wr_addr <= ptr;
                i2c_wr_data <= rx_byte;
            end
        end
    end

    // Bus write takes priority over a same-index host write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            host_rd_data <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i2c_we && ptr == 4'(i))
                    regs[i] <= rx_byte;
                else if (host_wr_stb && host_wr_addr == 4'(i))
                    regs[i] <= host_wr_data;
            end
            host_rd_data <= regs[host_rd_addr];
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on an open-drain SDA model, host port driven directly.
module tb_i2c_target;
    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic       scl_in, sda_in, sda_oe, i2c_wr_stb, busy;
    logic [3:0] i2c_wr_addr, host_wr_addr, host_rd_addr;
    logic [7:0] i2c_wr_data, host_wr_data, host_rd_data;
    logic       host_wr_stb;

    int         n_tests = 0, n_fail = 0;
    int         stb_n = 0, oe_viol = 0;
    logic       oe_prev = 1'b0;
    logic [3:0] stb_addr [16];
    logic [7:0] stb_data [16];

    assign scl_in = m_scl;
    assign sda_in = m_sda & ~sda_oe;

    always #10 clk = ~clk;

    i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
        .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data),
        .host_wr_stb(host_wr_stb), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (i2c_wr_stb && stb_n < 16) begin
            stb_addr[stb_n] = i2c_wr_addr;
            stb_data[stb_n] = i2c_wr_data;
        end
        if (i2c_wr_stb) stb_n = stb_n + 1;
    end

    // SDA drive must be stable whenever the controller holds SCL high.
    always @(posedge clk) begin
        if (rst_n && m_scl && sda_oe !== oe_prev) oe_viol <= oe_viol + 1;
        oe_prev <= sda_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        b = sda_in; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] v, input logic ack);
        logic b;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            v = {v[6:0], b};
        end
        send_bit(~ack);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_wr_addr = a; host_wr_data = d; host_wr_stb = 1'b1; tick(1);
        host_wr_stb = 1'b0;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [7:0] d);
        host_rd_addr = a; tick(2);
        d = host_rd_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        host_wr_stb = 1'b0; host_wr_addr = '0; host_wr_data = '0; host_rd_addr = '0;
        tick(3);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if ({i2c_wr_stb, i2c_wr_addr, i2c_wr_data} !== 13'h0) begin
            n_fail++; $display("FAIL reset_wr_outputs got %b/%h/%h want 0", i2c_wr_stb, i2c_wr_addr, i2c_wr_data); end
        rst_n = 1'b1; tick(3);
        host_read(4'd5, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg5 got %h want 00", d); end
    endtask

    task automatic test_register_write();
        logic a0, a1, a2, a3;
        logic [7:0] d;
        int s0;
        s0 = stb_n;
        i2c_start();
        write_byte(8'h84, a0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_after_addr got %b want 1", busy); end
        write_byte(8'h03, a1);
        write_byte(8'hA5, a2);
        write_byte(8'h5A, a3);
        i2c_stop(); tick(Q);
        n_tests++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL wr_acks got %b want 1111", {a0, a1, a2, a3}); end
        n_tests++; if (stb_n - s0 !== 2) begin n_fail++; $display("FAIL wr_stb_count got %0d want 2", stb_n - s0); end
        n_tests++; if ({stb_addr[s0], stb_data[s0]} !== 12'h3A5) begin
            n_fail++; $display("FAIL wr_stb0 got %h/%h want 3/a5", stb_addr[s0], stb_data[s0]); end
        n_tests++; if ({stb_addr[s0+1], stb_data[s0+1]} !== 12'h45A) begin
            n_fail++; $display("FAIL wr_stb1 got %h/%h want 4/5a", stb_addr[s0+1], stb_data[s0+1]); end
        host_read(4'd3, d);
        n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL wr_reg3 got %h want a5", d); end
        host_read(4'd4, d);
        n_tests++; if (d !== 8'h5A) begin n_fail++; $display("FAIL wr_reg4 got %h want 5a", d); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_wrap_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        host_write(4'd15, 8'h11);
        host_write(4'd0, 8'h22);
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a1);
        i2c_start();
        write_byte(8'h85, a2);
        read_byte(d0, 1'b1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mid got %b want 1", busy); end
        read_byte(d1, 1'b0);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_nack got %b want 0", busy); end
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_sda_released got %b want 0", sda_oe); end
        i2c_stop();
        n_tests++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rd_acks got %b want 111", {a0, a1, a2}); end
        n_tests++; if (d0 !== 8'h11) begin n_fail++; $display("FAIL rd_byte_idx15 got %h want 11", d0); end
        n_tests++; if (d1 !== 8'h22) begin n_fail++; $display("FAIL rd_byte_wrap_idx0 got %h want 22", d1); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1, a2;
        int s0;
        s0 = stb_n;
        i2c_start();
        write_byte(8'h86, a0);
        n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL mis_addr_ack got %b want 0", a0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy got %b want 0", busy); end
        write_byte(8'h00, a1);
        n_tests++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL mis_data_ack got %b want 0", a1); end
        n_tests++; if (stb_n !== s0) begin n_fail++; $display("FAIL mis_no_stb got %0d want %0d", stb_n, s0); end
        i2c_stop();
        i2c_start();
        write_byte(8'h84, a2);
        n_tests++; if ({a2, busy} !== 2'b11) begin n_fail++; $display("FAIL mis_next_match got ack %b busy %b want 1 1", a2, busy); end
        i2c_stop();
    endtask

    task automatic test_glitch_collision();
        logic a0, a1, a2, a3, seen;
        logic [7:0] cb, d;
        int k, s0;
        m_scl = 1'b1; m_sda = 1'b1; tick(Q);
        m_sda = 1'b0; tick(1);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
        write_byte(8'h84, a0);
        n_tests++; if ({a0, busy} !== 2'b00) begin n_fail++; $display("FAIL glitch_no_start got ack %b busy %b want 0 0", a0, busy); end
        i2c_stop();

        s0 = stb_n;
        cb = 8'h33;
        i2c_start();
        write_byte(8'h84, a1);
        write_byte(8'h07, a2);
        for (int i = 7; i >= 1; i--) send_bit(cb[i]);
        m_sda = cb[0]; tick(Q);
        host_wr_addr = 4'd7; host_wr_data = 8'h99; host_wr_stb = 1'b1;
        m_scl = 1'b1;
        seen = 1'b0; k = 0;
        while (!seen && k < 2 * Q) begin
            tick(1); k++;
            if (i2c_wr_stb) seen = 1'b1;
        end
        host_wr_stb = 1'b0;
        tick(2 * Q - k);
        m_scl = 1'b0; tick(Q);
        recv_bit(a3);
        i2c_stop();
        n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL coll_stb_seen got %b want 1", seen); end
        n_tests++; if ({a1, a2, a3} !== 3'b110) begin n_fail++; $display("FAIL coll_acks got %b want 110 (last is SDA level)", {a1, a2, a3}); end
        n_tests++; if ({stb_addr[s0], stb_data[s0]} !== 12'h733) begin
            n_fail++; $display("FAIL coll_stb got %h/%h want 7/33", stb_addr[s0], stb_data[s0]); end
        host_read(4'd7, d);
        n_tests++; if (d !== 8'h33) begin n_fail++; $display("FAIL coll_reg7 got %h want 33", d); end
    endtask

    task automatic test_abort();
        logic a0, a1, a2, a3, a4;
        logic [7:0] d;
        int s0;
        s0 = stb_n;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h01, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        write_byte(8'h84, a2);
        n_tests++; if ({a2, busy} !== 2'b11) begin n_fail++; $display("FAIL abort_readdr got ack %b busy %b want 1 1", a2, busy); end
        n_tests++; if (stb_n !== s0) begin n_fail++; $display("FAIL abort_no_stb got %0d want %0d", stb_n, s0); end
        write_byte(8'h02, a3);
        write_byte(8'h5C, a4);
        i2c_stop(); tick(Q);
        n_tests++; if ({a0, a1, a3, a4} !== 4'b1111) begin n_fail++; $display("FAIL abort_acks got %b want 1111", {a0, a1, a3, a4}); end
        n_tests++; if ({stb_n - s0 == 1, stb_addr[s0], stb_data[s0]} !== 13'h125C) begin
            n_fail++; $display("FAIL abort_stb got n=%0d %h/%h want n=1 2/5c", stb_n - s0, stb_addr[s0], stb_data[s0]); end
        host_read(4'd1, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_reg1 got %h want 00", d); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        logic [7:0] d;
        host_write(4'd5, 8'h3C);
        host_read(4'd5, d);
        n_tests++; if (d !== 8'h3C) begin n_fail++; $display("FAIL rst_pre_reg5 got %h want 3c", d); end
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h05, a1);
        i2c_start();
        write_byte(8'h85, a2);
        n_tests++; if ({a0, a1, a2, sda_oe} !== 4'b1111) begin
            n_fail++; $display("FAIL rst_read_drive got acks %b oe %b want 111 1", {a0, a1, a2}, sda_oe); end
        m_scl = 1'b1; tick(Q);
        rst_n = 1'b0;
        #1;
        n_tests++; if ({sda_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_async_release got oe %b busy %b want 0 0", sda_oe, busy); end
        m_sda = 1'b1; tick(3);
        rst_n = 1'b1; tick(Q);
        host_read(4'd5, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_post_reg5 got %h want 00", d); end
    endtask

    task automatic test_oe_timing();
        n_tests++; if (oe_viol !== 0) begin n_fail++; $display("FAIL oe_stable_scl_high got %0d changes want 0", oe_viol); end
    endtask

    initial begin
        test_reset();
        test_register_write();
        test_wrap_read();
        test_addr_mismatch();
        test_glitch_collision();
        test_abort();
        test_reset_mid_read();
        test_oe_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) with a 16 x 8-bit register file. It is the other end of the bus driven by the `i2c` master block.
- It lets an external I2C controller, or a second board running the master firmware, read and write transceiver status/control bytes.
- It sits in the clk_50 domain next to the master and shares the open-drain pad pattern (pad driven low or released).
- Fabric logic gets a write-strobe stream of I2C writes and a local port to update registers.

Parameters:
- ADDRESS, 7'h42, 7-bit target address matched after START.
- FILTER, 3, number of consecutive equal synchronised samples needed before an SCL/SDA level change is accepted.

Ports:
- clk  input  1  system clock (clk_50).
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  SCL pad level (asynchronous).
- sda_in  input  1  SDA pad level (asynchronous).
- sda_oe  output  1  1 = drive SDA pad low, 0 = release.
- i2c_wr_stb  output  1  one-cycle pulse per byte written over I2C.
- i2c_wr_addr  output  4  register index of that write.
- i2c_wr_data  output  8  data of that write.
- host_wr_stb  input  1  fabric write enable.
- host_wr_addr  input  4  fabric write index.
- host_wr_data  input  8  fabric write data.
- host_rd_addr  input  4  fabric read index.
- host_rd_data  output  8  register[host_rd_addr], registered, 1-cycle latency.
- busy  output  1  high from accepted START with address match until STOP/START/NACK-end.

Behaviour:
- Reset (asynchronous): all outputs 0, all registers 0, pointer 0, state IDLE, SDA released immediately. Reset mid-transfer aborts with no strobe.
- Input conditioning:
  - scl_in and sda_in each pass through 2 flip-flops, then a FILTER-sample glitch filter.
  - Edge and condition detection uses the filtered levels only.
- Bus conditions:
  - START = SDA high→low while SCL high.
  - STOP = SDA low→high while SCL high.
  - START in any state (including repeated START): go to ADDR, bit counter cleared, sda_oe=0.
  - STOP in any state: go to IDLE, sda_oe=0, busy=0.
- Timing rules:
  - Data is sampled on filtered SCL rising edge.
  - sda_oe changes only on the cycle after a filtered SCL falling edge, never while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
    - On the 8th rise, if bits[7:1]==ADDRESS, go to ADDR_ACK with rw=bit0.
    - On mismatch, go to IDLE (no ACK, bus ignored until the next START).
  - ADDR_ACK: drive SDA low for the 9th clock.
    - Set busy=1 at entry.
    - After the 9th falling edge: rw=0 → PTR; rw=1 → load the byte at the pointer and go to RDATA.
  - PTR: receive 8 bits.
    - pointer ← byte[3:0]; bits [7:4] are ignored.
    - Go to PTR_ACK (ACK driven), then WDATA.
  - WDATA: receive 8 bits, then go to WDATA_ACK (ACK driven).
    - On the 8th rise: write register[pointer], pulse i2c_wr_stb with the pointer and data, pointer ← pointer+1 mod 16 (15 wraps to 0).
    - Then return to WDATA. The target never NACKs writes.
  - RDATA: shift out register[pointer] MSB first.
    - sda_oe = ~bit. The first bit is driven after the ADDR_ACK falling edge.
    - After 8 bits, release SDA, pointer ← pointer+1 mod 16, go to MACK.
  - MACK: sample SDA on the 9th rise.
    - 0 (ACK): load the next byte and go to RDATA.
    - 1 (NACK): release SDA, go to IDLE, busy=0.
- Collisions:
  - A host write and an I2C write to the same index in the same cycle: the I2C write wins and the host write is dropped.
  - A host write to the byte currently being shifted out does not alter that byte; it was latched at load.
- host_rd_data is continuously available, independent of bus activity.
- A pointer set by a write transaction persists into a following read (repeated START or a new transaction).

Test Plan:
- Reset values: assert rst_n=0 mid-RDATA with sda_oe=1 → sda_oe=0 within the same cycle; after release, host_rd_addr=5 → host_rd_data=8'h00.
- Register write: S 0x84 A 0x03 A 0xA5 A 0x5A A P → ACK on all 4 bytes; i2c_wr_stb pulses twice, (3,A5) then (4,5A); host reads index 3 → A5 and index 4 → 5A.
- Wrap-around read: host writes idx15=0x11, idx0=0x22. S 0x84 0x0F Sr 0x85 → target returns 0x11, master ACK, 0x22, master NACK, P → busy falls after NACK; SDA released.
- Address mismatch: S 0x86 ... → no ACK (SDA stays high on the 9th clock); no strobes; busy stays 0 until the next matching START.
- Glitch and collision:
  - 1-cycle SDA low pulse while SCL high → no START detected.
  - host_wr_stb to idx 7 in the same cycle as an I2C write of 0x33 to idx 7 → register 7 = 0x33.
- Abort: START in the middle of WDATA after 4 bits → no strobe, state ADDR, the next full address is decoded correctly.
